// File: rtl/dsp_acc_pkg.sv
// rtl/dsp_acc_pkg.sv - shared types, defaults and saturation limits for the frame accumulator
package dsp_acc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    localparam int DEF_IN_WIDTH   = 48;
    localparam int DEF_OUT_WIDTH  = 48;
    localparam int DEF_GUARD_BITS = 8;
    localparam int LEN_WIDTH      = 8;
    localparam int LIMIT_WIDTH    = 128;

    // Largest positive value representable in out_w signed bits
    function automatic logic signed [LIMIT_WIDTH-1:0] sat_pos_limit(input int out_w);
        logic signed [LIMIT_WIDTH-1:0] one;
        one = 128'sd1;
        return (one <<< (out_w - 1)) - one;
    endfunction

    // Most negative value representable in out_w signed bits
    function automatic logic signed [LIMIT_WIDTH-1:0] sat_neg_limit(input int out_w);
        logic signed [LIMIT_WIDTH-1:0] one;
        one = 128'sd1;
        return -(one <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/dsp_acc_fifo2.sv
// rtl/dsp_acc_fifo2.sv - two-entry result queue with same-cycle push/pop at any occupancy
module dsp_acc_fifo2 #(
    parameter int WIDTH = 49
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             do_push;
    logic             do_pop;

    // Readiness depends only on occupancy so the upstream never sees the consumer's ready
    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = e0_q;

    assign do_pop  = m_tvalid && m_tready;
    assign do_push = s_tvalid && (s_tready || do_pop);

    // Next occupancy and entry contents; e0 is always the head
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case ({do_push, do_pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = s_tdata;
                end else begin
                    e0_d = e1_q;
                    e1_d = s_tdata;
                end
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d = s_tdata;
                end else begin
                    e1_d = s_tdata;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            default: ;
        endcase
    end

    // Queue registers; reset empties the queue and zeroes the head so outputs read 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: rtl/dsp_acc_stage.sv
// rtl/dsp_acc_stage.sv - frame accumulator with final-sum saturation and a two-entry result queue
module dsp_acc_stage
    import dsp_acc_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    input  logic [LEN_WIDTH-1:0]        frame_len,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_sat
);

    localparam int ACC_W  = IN_WIDTH + GUARD_BITS;
    localparam int FIFO_W = OUT_WIDTH + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_pos_limit(OUT_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_neg_limit(OUT_WIDTH));

    acc_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;

    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  final_sum;
    logic                     frame_done;
    logic                     accept;
    logic                     fifo_s_tready;
    logic                     sat_flag;
    logic [OUT_WIDTH-1:0]     sat_data;
    logic [FIFO_W-1:0]        push_word;
    logic [FIFO_W-1:0]        head_word;

    assign sample_ext = ACC_W'(in_data);
    assign in_ready   = rst_n && fifo_s_tready && !clear;
    assign accept     = in_valid && in_ready;

    // Frame sequencing: first sample loads and latches the length, later samples add until the count matches
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        final_sum  = acc_q;
        frame_done = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    len_d     = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
                    acc_d     = sample_ext;
                    cnt_d     = LEN_WIDTH'(1);
                    final_sum = sample_ext;
                    if (len_d == LEN_WIDTH'(1)) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_d     = acc_q + sample_ext;
                    cnt_d     = cnt_q + LEN_WIDTH'(1);
                    final_sum = acc_d;
                    if (cnt_d == len_q) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Accumulator state; the latched length resets to 1 so an idle stage behaves as single-sample frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_WIDTH'(1);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Clip only the completed frame sum to the output range and flag the clip
    always_comb begin
        sat_flag = 1'b0;
        sat_data = final_sum[OUT_WIDTH-1:0];
        if (final_sum > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_data = SAT_MAX[OUT_WIDTH-1:0];
        end else if (final_sum < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_data = SAT_MIN[OUT_WIDTH-1:0];
        end
        push_word = {sat_flag, sat_data};
    end

    dsp_acc_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (frame_done),
        .s_tready (fifo_s_tready),
        .s_tdata  (push_word),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (head_word)
    );

    assign out_data = head_word[OUT_WIDTH-1:0];
    assign out_sat  = head_word[OUT_WIDTH];

endmodule
